pi_level_ctl: RTL
=================

// Module: pi_level_ctl
// PURPOSE
//  Priority-interrupt level controller: the stage directly upstream of CON. Holds the seven PI levels
//  (on, program-request, hold). Raises READY to CON for the highest eligible level. Runs the EBUS PI
//  handshake that CON microcode skips on (EBUS_CP_GRANT, EXT_TRAN_REC). Consumes CONO_PI, PI_DISABLE,
//  SET_PIH, PI_DISMISS and EBUS_REL from CON.
// PARAMETERS
//  FUNC_CYCLES     2    cycles EBUS PI function/level is driven before waiting for device ack (>=1)
//  TIMEOUT_CYCLES  64   device-ack timeout in WAIT_DEV (only with KL_PI_TIMEOUT_EN)
// PORTS
//  clk            in   1      single clock; all state changes on posedge
//  RESET_N        in   1      synchronous, active-low reset
//  CONO_PI        in   1      one-cycle CONO PI strobe from CON
//  EBUS_DATA      in   [18:35] CONO PI operand
//  EBUS_PI        in   [1:7]  device interrupt request lines, level-sensitive, already synchronized
//  PI_DISABLE     in   1      CON: run off or EBOX halted; suppresses READY
//  PI_CYCLE       in   1      CON: PI cycle in progress; starts the EBUS handshake
//  SET_PIH        in   1      one-cycle strobe: set hold for the granted level
//  PI_DISMISS     in   1      one-cycle strobe: clear the highest-priority hold
//  EBUS_REL       in   1      CON releases the EBUS
//  EBUS_GRANT_IN  in   1      EBUS arbiter grant
//  EBUS_ACK       in   1      device acknowledge; vector valid on EBUS_VEC
//  EBUS_VEC       in   36     device-supplied interrupt function word
//  READY          out  1      interrupt request to CON
//  PI_LEVEL       out  3      level being requested or serviced (1=highest, 0=none)
//  EBUS_REQ       out  1      request EBUS from arbiter
//  EBUS_PI_FUNC   out  1      drive PI function + PI_LEVEL onto EBUS
//  EBUS_CP_GRANT  out  1      EBUS owned for the PI transaction
//  EXT_TRAN_REC   out  1      one-cycle pulse: device vector latched
//  PI_VEC         out  36     latched device vector
//  PI_STATUS      out  [18:35] CONI PI word: 21 timeout, 28 PI on, 29:35 levels on; others 0
// BEHAVIOUR
//  Reset (RESET_N=0 at posedge): all outputs 0; on/req/hold cleared; PI off; state IDLE, including mid-handshake.
//  CONO_PI decode, bits 29:35 = level mask L[1:7]:
//    22 drop program requests on L; 23 clear PI system (on, req, hold, PI-on, timeout flag)
//    24 set program requests on L; 25 turn on L; 26 turn off L; 27 PI off; 28 PI on
//    Bit 23 takes precedence over all other bits in the same word.
//  pending[n] = (req[n] | EBUS_PI[n]) & on[n] & PI-on
//  eligible[n] = pending[n] & no hold at level <= n
//  best = lowest-numbered eligible level
//  READY, registered with 1-cycle latency: any eligible & ~PI_DISABLE & state==IDLE. It drops the cycle
//    after state leaves IDLE.
//  PI_LEVEL: registered best while IDLE; frozen from leaving IDLE until return to IDLE.
//  FSM:
//    IDLE     -> REQ when PI_CYCLE & READY. Latch level.
//    REQ      EBUS_REQ=1; -> FUNC on EBUS_GRANT_IN.
//    FUNC     EBUS_CP_GRANT=1; EBUS_PI_FUNC=1 for FUNC_CYCLES; -> WAIT_DEV.
//    WAIT_DEV EBUS_CP_GRANT=1; on EBUS_ACK latch PI_VEC and pulse EXT_TRAN_REC -> REL.
//    REL      EBUS_CP_GRANT=1 until EBUS_REL -> IDLE.
//    EBUS_REL in any non-IDLE state aborts to IDLE. No EXT_TRAN_REC is issued.
//  SET_PIH sets hold[latched level] and clears req[that level] in the same cycle.
//  PI_DISMISS clears the lowest-numbered set hold. The hold set evaluated is the one before this cycle's SET_PIH.
//  Simultaneous SET_PIH + CONO bit 23: clear wins. Counter/FUNC timer never wraps: saturates, then resets on state exit.
// CONFIGURATION
//  `KL_PI_TIMEOUT_EN defined:
//    TIMEOUT_CYCLES without EBUS_ACK in WAIT_DEV sets status bit 21 and goes to REL without EXT_TRAN_REC.
//    Bit 21 is cleared by CONO bit 23.
//  `KL_PI_TIMEOUT_EN undefined: WAIT_DEV waits indefinitely; bit 21 reads 0; no counter logic.
// STRUCTURE
//  ebox.svh:
//    enum tPIState {IDLE, REQ, FUNC, WAIT_DEV, REL}
//    CONO PI bit-position localparams
//  Sub-module pi_prio_enc: [1:7] mask -> 3-bit lowest-set index plus any flag.
// TESTING
//  1. Reset, then CONO 0x... bits 28,25, L=0100000 (level 2), EBUS_PI[2]=1 -> READY=1 two cycles later, PI_LEVEL=2.
//  2. Full handshake on level 2:
//       PI_CYCLE, GRANT_IN after 3 cycles, ACK with VEC=36'o000040_000042
//       -> EBUS_PI_FUNC high exactly FUNC_CYCLES=2
//       -> EXT_TRAN_REC one pulse; PI_VEC=000040000042
//       -> IDLE after EBUS_REL
//  3. Priority and hold:
//       hold[3] set; pending on levels 5 and 2 -> PI_LEVEL=2
//       SET_PIH -> level 5 ineligible
//       PI_DISMISS twice -> holds cleared in order 2 then 3; READY reasserts for 5
//  4. PI_DISABLE=1 with eligible level 1 -> READY=0. PI_STATUS[28] stays 1.
//  5. CONO with bits 23 and 24 together while in WAIT_DEV and holds set
//       -> all req/on/hold cleared, no req set
//       -> FSM unaffected until EBUS_REL
//  6. With KL_PI_TIMEOUT_EN, TIMEOUT_CYCLES=64, no ACK -> cycle 64: status bit 21=1, REL, no EXT_TRAN_REC.
//     Without the macro the FSM stays in WAIT_DEV after 1000 cycles.
//     RESET_N low mid-FSM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pi_level_ctl_pkg.sv
// ============================================================================
// Module : pi_level_ctl_pkg
// Brief  : Shared types and CONO/CONI PI bit positions for the PI level controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pi_level_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_FUNC     = 3'd2,
    ST_WAIT_DEV = 3'd3,
    ST_REL      = 3'd4
  } pi_state_e;

  localparam int c_NUM_LEVELS = 7;

  // CONO PI operand bit positions (PDP-10 numbering, bit 18 is the MSB of the half-word)
  localparam int c_CONO_DROP_REQ = 22;
  localparam int c_CONO_CLEAR    = 23;
  localparam int c_CONO_SET_REQ  = 24;
  localparam int c_CONO_LVL_ON   = 25;
  localparam int c_CONO_LVL_OFF  = 26;
  localparam int c_CONO_PI_OFF   = 27;
  localparam int c_CONO_PI_ON    = 28;
  localparam int c_LVL_FIRST     = 29;

  // CONI PI status bit positions
  localparam int c_STAT_TIMEOUT  = 21;
  localparam int c_STAT_PI_ON    = 28;

endpackage

`default_nettype wire

// File: rtl/pi_prio_enc.sv
// ============================================================================
// Module : pi_prio_enc
// Brief  : Returns the lowest-numbered set level of a [1:7] mask (0 if none).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pi_prio_enc
  import pi_level_ctl_pkg::*;
(
  input  logic [1:c_NUM_LEVELS] i_mask,
  output logic [2:0]            o_idx,
  output logic                  o_any
);

  always_comb begin
    o_idx = '0;
    for (int n = c_NUM_LEVELS; n >= 1; n--) begin
      if (i_mask[n]) o_idx = 3'(n);
    end
  end

  assign o_any = |i_mask;

endmodule

`default_nettype wire

// File: rtl/pi_level_ctl.sv
// ============================================================================
// Module : pi_level_ctl
// Brief  : PI level controller: level state, READY to CON, EBUS PI handshake.
//          Optional device-ack timeout enabled by `KL_PI_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pi_level_ctl
  import pi_level_ctl_pkg::*;
#(
  parameter int FUNC_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 64
)(
  input  logic                  clk,
  input  logic                  RESET_N,
  input  logic                  CONO_PI,
  input  logic [18:35]          EBUS_DATA,
  input  logic [1:c_NUM_LEVELS] EBUS_PI,
  input  logic                  PI_DISABLE,
  input  logic                  PI_CYCLE,
  input  logic                  SET_PIH,
  input  logic                  PI_DISMISS,
  input  logic                  EBUS_REL,
  input  logic                  EBUS_GRANT_IN,
  input  logic                  EBUS_ACK,
  input  logic [35:0]           EBUS_VEC,
  output logic                  READY,
  output logic [2:0]            PI_LEVEL,
  output logic                  EBUS_REQ,
  output logic                  EBUS_PI_FUNC,
  output logic                  EBUS_CP_GRANT,
  output logic                  EXT_TRAN_REC,
  output logic [35:0]           PI_VEC,
  output logic [18:35]          PI_STATUS
);

`ifdef KL_PI_TIMEOUT_EN
  localparam int c_CNT_MAX = (FUNC_CYCLES > TIMEOUT_CYCLES) ? FUNC_CYCLES : TIMEOUT_CYCLES;
`else
  localparam int c_CNT_MAX = FUNC_CYCLES;
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
`endif
  localparam int c_CW = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CW-1:0] c_FUNC_LAST = c_CW'(FUNC_CYCLES - 1);
  localparam logic [c_CW-1:0] c_CNT_SAT   = c_CW'(c_CNT_MAX);

  pi_state_e                 r_state, w_next;
  logic [1:c_NUM_LEVELS]     r_on, r_req, r_hold;
  logic [1:c_NUM_LEVELS]     w_on_nxt, w_req_nxt, w_hold_nxt;
  logic [1:c_NUM_LEVELS]     w_pending, w_elig, w_lvl;
  logic                      r_pi_on, w_pi_on_nxt, r_ready, r_etr;
  logic [2:0]                r_level, w_best, w_hold_low;
  logic                      w_any, w_hold_any, w_blocked, w_clear, w_ack_take, w_counting;
  logic [35:0]               r_vec;
  logic [c_CW-1:0]           r_cnt;
  logic                      w_unused;

  assign w_unused = ^EBUS_DATA[18:21];
  assign w_lvl    = EBUS_DATA[c_LVL_FIRST +: c_NUM_LEVELS];
  assign w_clear  = CONO_PI & EBUS_DATA[c_CONO_CLEAR];

  // A hold at any level <= n blocks level n.
  always_comb begin
    w_pending = (r_req | EBUS_PI) & r_on & {c_NUM_LEVELS{r_pi_on}};
    w_blocked = 1'b0;
    w_elig    = '0;
    for (int n = 1; n <= c_NUM_LEVELS; n++) begin
      w_blocked = w_blocked | r_hold[n];
      w_elig[n] = w_pending[n] & ~w_blocked;
    end
  end

  pi_prio_enc u_best_enc (.i_mask(w_elig), .o_idx(w_best),     .o_any(w_any));
  pi_prio_enc u_hold_enc (.i_mask(r_hold), .o_idx(w_hold_low), .o_any(w_hold_any));

`ifdef KL_PI_TIMEOUT_EN
  localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT_CYCLES - 1);
  logic w_to_hit, r_timeout;
`endif

  always_comb begin
    w_next        = r_state;
    w_ack_take    = 1'b0;
`ifdef KL_PI_TIMEOUT_EN
    w_to_hit      = 1'b0;
`endif
    EBUS_REQ      = (r_state == ST_REQ);
    EBUS_PI_FUNC  = (r_state == ST_FUNC);
    EBUS_CP_GRANT = (r_state == ST_FUNC) || (r_state == ST_WAIT_DEV) || (r_state == ST_REL);
    case (r_state)
      ST_IDLE:     if (PI_CYCLE && r_ready) w_next = ST_REQ;
      ST_REQ:      if (EBUS_GRANT_IN) w_next = ST_FUNC;
      ST_FUNC:     if (r_cnt == c_FUNC_LAST) w_next = ST_WAIT_DEV;
      ST_WAIT_DEV: begin
        if (EBUS_ACK) begin
          w_next     = ST_REL;
          w_ack_take = 1'b1;
        end
`ifdef KL_PI_TIMEOUT_EN
        else if (r_cnt == c_TO_LAST) begin
          w_next   = ST_REL;
          w_to_hit = 1'b1;
        end
`endif
      end
      ST_REL:      if (EBUS_REL) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    // CON releasing the bus abandons the transaction with no vector delivered.
    if (r_state != ST_IDLE && EBUS_REL) begin
      w_next     = ST_IDLE;
      w_ack_take = 1'b0;
`ifdef KL_PI_TIMEOUT_EN
      w_to_hit   = 1'b0;
`endif
    end
  end

  always_comb begin
    w_on_nxt    = r_on;
    w_req_nxt   = r_req;
    w_hold_nxt  = r_hold;
    w_pi_on_nxt = r_pi_on;
    if (CONO_PI) begin
      if (EBUS_DATA[c_CONO_DROP_REQ]) w_req_nxt = w_req_nxt & ~w_lvl;
      if (EBUS_DATA[c_CONO_SET_REQ])  w_req_nxt = w_req_nxt | w_lvl;
      if (EBUS_DATA[c_CONO_LVL_ON])   w_on_nxt  = w_on_nxt | w_lvl;
      if (EBUS_DATA[c_CONO_LVL_OFF])  w_on_nxt  = w_on_nxt & ~w_lvl;
      if (EBUS_DATA[c_CONO_PI_OFF])   w_pi_on_nxt = 1'b0;
      if (EBUS_DATA[c_CONO_PI_ON])    w_pi_on_nxt = 1'b1;
    end
    if (PI_DISMISS && w_hold_any) w_hold_nxt[w_hold_low] = 1'b0;
    if (SET_PIH && r_level != 3'd0) begin
      w_hold_nxt[r_level] = 1'b1;
      w_req_nxt[r_level]  = 1'b0;
    end
    if (w_clear) begin
      w_on_nxt    = '0;
      w_req_nxt   = '0;
      w_hold_nxt  = '0;
      w_pi_on_nxt = 1'b0;
    end
  end

`ifdef KL_PI_TIMEOUT_EN
  assign w_counting = (r_state == ST_FUNC) || (r_state == ST_WAIT_DEV);
`else
  assign w_counting = (r_state == ST_FUNC);
`endif

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_on    <= '0;
      r_req   <= '0;
      r_hold  <= '0;
      r_pi_on <= 1'b0;
      r_ready <= 1'b0;
      r_level <= '0;
      r_etr   <= 1'b0;
      r_vec   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_on    <= w_on_nxt;
      r_req   <= w_req_nxt;
      r_hold  <= w_hold_nxt;
      r_pi_on <= w_pi_on_nxt;
      r_ready <= w_any & ~PI_DISABLE & (r_state == ST_IDLE);
      if (r_state == ST_IDLE && w_next == ST_IDLE) r_level <= w_best;
      r_etr   <= w_ack_take;
      if (w_ack_take) r_vec <= EBUS_VEC;
      if (w_next != r_state)                r_cnt <= '0;
      else if (w_counting && r_cnt != c_CNT_SAT) r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef KL_PI_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!RESET_N) r_timeout <= 1'b0;
    else          r_timeout <= (r_timeout | w_to_hit) & ~w_clear;
  end
`endif

  always_comb begin
    PI_STATUS = '0;
`ifdef KL_PI_TIMEOUT_EN
    PI_STATUS[c_STAT_TIMEOUT] = r_timeout;
`endif
    PI_STATUS[c_STAT_PI_ON] = r_pi_on;
    PI_STATUS[c_LVL_FIRST +: c_NUM_LEVELS] = r_on;
  end

  assign READY        = r_ready;
  assign PI_LEVEL     = r_level;
  assign EXT_TRAN_REC = r_etr;
  assign PI_VEC       = r_vec;

endmodule

`default_nettype wire
